apb_block_cipher_fifo_wrapper: RTL
==================================

# apb_block_cipher_fifo_wrapper

APB slave that feeds a block-cipher core (request/ack/busy/valid handshake, e.g. kuznechik_cipher) from an input FIFO and collects results into an output FIFO. This is the parametrised successor to the single-block register wrapper: block width, FIFO depth and an interrupt are configurable, and an autonomous FSM streams queued blocks through the core without per-block CPU handshaking. It sits on the peripheral APB bus; the core is instantiated beside it and connected through the core_* ports.

## Interface
- APB_ADDR_WIDTH, 12, APB address width
- APB_DATA_WIDTH, 32, APB data width
- BLOCK_WIDTH, 128, cipher block width; integer multiple of APB_DATA_WIDTH; WORDS = BLOCK_WIDTH/APB_DATA_WIDTH
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..128
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  reset; asynchronous, active-low
- apb_paddr_i / apb_pwdata_i / apb_pwrite_i / apb_psel_i / apb_penable_i  in  APB_ADDR_WIDTH / APB_DATA_WIDTH / 1 / 1 / 1  APB request
- apb_prdata_o / apb_pready_o / apb_pslverr_o  out  APB_DATA_WIDTH / 1 / 1  APB response; all reset to 0
- core_rstn_o  out  1  = rstn_i & CTRL.EN & ~flush_pulse
- core_req_o / core_ack_o  out  1 / 1  one-cycle pulses; reset 0
- core_data_o  out  BLOCK_WIDTH  input FIFO head, registered at request; reset 0
- core_busy_i / core_valid_i  in  1 / 1  core status
- core_data_i  in  BLOCK_WIDTH  core result, sampled while core_valid_i is high
- irq_o  out  1  level interrupt; reset 0

## Operation
- Register map (word offsets). Addresses with paddr[1:0] != 0 are errors.
  - 0x000 CTRL RW: bit0 EN, bit1 FLUSH (write-1 self-clearing, reads 0), bit2 IRQ_EN.
  - 0x004 STATUS RO: bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty, bit4 core_busy_i, [15:8] in_count, [23:16] out_count.
  - 0x008 IRQ W1C: bit0 DONE (result pushed), bit1 OVF (push to full input FIFO), bit2 UDF (pop from empty output FIFO).
  - 0x00C PUSH WO: any write copies the DATA_IN staging words into the input FIFO.
  - 0x010 POP WO: any write discards the output FIFO head.
  - 0x100+4i DATA_IN[i] RW, i < WORDS; staging register; word 0 = bits [31:0].
  - 0x200+4i DATA_OUT[i] RO; output FIFO head word i; reads 0 when empty.
- pslverr conditions: unmapped address, unaligned address, write to STATUS/DATA_OUT, read of PUSH/POP. An erroring access has no side effect.
- Core FSM:
  - IDLE -> REQ when EN & ~in_empty & ~core_busy_i. Load core_data_o from the head and pop it.
  - REQ: core_req_o=1 for one cycle -> WAIT.
  - WAIT -> ACK when core_valid_i & ~out_full. Push core_data_i and set DONE. While the output FIFO is full the FSM stays in WAIT (backpressure).
  - ACK: core_ack_o=1 for one cycle -> IDLE.
- EN cleared in any state: the FSM goes to IDLE, the in-flight block is lost, and the FIFOs are retained.
- FLUSH: both FIFOs are emptied, the FSM goes to IDLE, core_rstn_o is held low for exactly one cycle, and IRQ flags are unchanged.
- PUSH when full: the data is dropped and OVF is set. A PUSH in the same cycle as an FSM pop on a full FIFO is still dropped, because fullness is evaluated before the pop. The same rule applies to a POP on an empty output FIFO racing an FSM push: it counts as a UDF.
- irq_o = IRQ_EN & |IRQ. A W1C clear in the same cycle as a hardware set leaves the flag set.

## Timing
- Every access phase lasts exactly 2 cycles. apb_pready_o is registered and is high in the second penable cycle only. prdata and pslverr are registered and valid while pready is high.
- Write side effects commit at the clock edge that ends the first penable cycle.
- PUSH commits at edge E with FSM in IDLE, EN=1, core idle -> core_req_o high in the cycle after E+1 (REQ state). in_count drops at E+1.
- core_valid_i sampled high at edge V with out not full -> out_count increments, DONE is set and core_ack_o goes high, all visible after V.
- Asynchronous reset mid-operation: all registers, FIFO pointers, flags and the FSM return to reset state immediately. Reset values: CTRL=0, so core_rstn_o=0.

## Configuration
- CIPHER_WRAP_IRQ_EN defined: the IRQ register, CTRL.IRQ_EN and irq_o behave as specified.
- Undefined: the IRQ register reads 0, writes to it are accepted with no effect and no error, CTRL bit2 reads 0, irq_o is tied 0, and no flag logic is built.

## Test plan
- Reset, then read CTRL/STATUS -> 0x0 / 0x0A; irq_o=0; core_rstn_o=0.
- EN=1, write DATA_IN 0..3 = 0x33221100.., PUSH; core model returns the block inverted after 5 cycles -> exactly one core_req_o and one core_ack_o pulse; DATA_OUT[0]=0xCCDDEEFF; DONE=1; irq_o=1 with IRQ_EN.
- FIFO_DEPTH=4, EN=0, 5 PUSHes -> in_count=4, OVF=1; W1C 0x2 -> IRQ=0x1 cleared of OVF.
- Core model never asserts pops; fill output FIFO, then hold core_valid_i -> FSM stays in WAIT with no ack; one POP -> ack follows.
- FLUSH during WAIT -> counts=0, core_rstn_o low for 1 cycle, no ack; write to 0x204 and access to 0x102 -> pslverr=1.

Source files
------------

// File: rtl/apb_block_cipher_fifo_wrapper.sv
// apb_block_cipher_fifo_wrapper
//
// APB slave that feeds a request/ack/busy/valid block-cipher core from an
// input FIFO and collects its results in an output FIFO. Queued blocks are
// streamed through the core by an FSM, with no CPU handshake per block.
//
// Optional feature macro: CIPHER_WRAP_IRQ_EN
//   defined   : IRQ flag register (DONE/OVF/UDF), CTRL.IRQ_EN and irq_o active
//   undefined : IRQ register reads 0 and ignores writes, CTRL bit2 reads 0,
//               irq_o tied low
//
// Ports
//   clk_i, rstn_i                 clock, async active-low reset
//   apb_*_i / apb_*_o             APB slave (fixed two-cycle access phase)
//   core_rstn_o                   core reset: low when disabled, or one cycle on flush
//   core_req_o / core_ack_o       one-cycle request / result-acknowledge pulses
//   core_data_o                   block sent to the core (input FIFO head)
//   core_busy_i / core_valid_i    core status
//   core_data_i                   core result, taken while core_valid_i is high
//   irq_o                         level interrupt
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for EN, a queued block and an idle core
//   REQ     | core_req_o pulse, block already loaded into core_data_o
//   WAIT    | waiting for core_valid_i with room in the output FIFO
//   ACK     | core_ack_o pulse, result already pushed

module apb_block_cipher_fifo_wrapper #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 128,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic                      core_rstn_o,
    output logic                      core_req_o,
    output logic                      core_ack_o,
    output logic [BLOCK_WIDTH-1:0]    core_data_o,
    input  logic                      core_busy_i,
    input  logic                      core_valid_i,
    input  logic [BLOCK_WIDTH-1:0]    core_data_i,
    output logic                      irq_o
);

    localparam int WORDS = BLOCK_WIDTH / APB_DATA_WIDTH;
    localparam int DW    = APB_DATA_WIDTH;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [APB_ADDR_WIDTH-9:0] PG_REG  = (APB_ADDR_WIDTH-8)'(0);
    localparam logic [APB_ADDR_WIDTH-9:0] PG_DIN  = (APB_ADDR_WIDTH-8)'(1);
    localparam logic [APB_ADDR_WIDTH-9:0] PG_DOUT = (APB_ADDR_WIDTH-8)'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ACK} state_t;

    // ---------------- registers ----------------
    state_t                 state_q, state_d;
    logic                   req_q, req_d, ack_q, ack_d;
    logic [BLOCK_WIDTH-1:0] core_data_q, core_data_d;

    logic                   ctrl_en_q, ctrl_en_d;
    logic                   flush_q, flush_d;
    logic [BLOCK_WIDTH-1:0] din_q, din_d;

    logic [BLOCK_WIDTH-1:0] in_mem_q [FIFO_DEPTH];
    logic [BLOCK_WIDTH-1:0] in_mem_d [FIFO_DEPTH];
    logic [PW-1:0]          in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [CW-1:0]          in_cnt_q, in_cnt_d;

    logic [BLOCK_WIDTH-1:0] out_mem_q [FIFO_DEPTH];
    logic [BLOCK_WIDTH-1:0] out_mem_d [FIFO_DEPTH];
    logic [PW-1:0]          out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;

    logic                   pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DW-1:0]          prdata_q, prdata_d;

    // ---------------- APB decode ----------------
    logic                      access, aligned, din_hit;
    logic [APB_ADDR_WIDTH-9:0] page;
    logic [5:0]                woff;
    logic sel_ctrl, sel_status, sel_irq, sel_push, sel_pop, sel_din, sel_dout;
    logic acc_err, acc_wr, acc_rd;
    logic push_req, pop_req, flush;
    logic in_full, in_empty, out_full, out_empty;
    logic in_push_ok, out_pop_ok, fsm_pop, fsm_push;
    logic [2:0] irq_rd;
    logic       irq_en_rd;

    // Pready is high only in the second penable cycle, so the first one is the
    // single cycle where an access is decoded and committed.
    assign access  = apb_psel_i & apb_penable_i & ~pready_q;
    assign aligned = (apb_paddr_i[1:0] == 2'b00);
    assign page    = apb_paddr_i[APB_ADDR_WIDTH-1:8];
    assign woff    = apb_paddr_i[7:2];

    always_comb begin
        din_hit = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (woff == 6'(i)) din_hit = 1'b1;
        end
    end

    assign sel_ctrl   = aligned && page == PG_REG  && woff == 6'd0;
    assign sel_status = aligned && page == PG_REG  && woff == 6'd1;
    assign sel_irq    = aligned && page == PG_REG  && woff == 6'd2;
    assign sel_push   = aligned && page == PG_REG  && woff == 6'd3;
    assign sel_pop    = aligned && page == PG_REG  && woff == 6'd4;
    assign sel_din    = aligned && page == PG_DIN  && din_hit;
    assign sel_dout   = aligned && page == PG_DOUT && din_hit;

    assign acc_err = access & (~(sel_ctrl | sel_status | sel_irq | sel_push | sel_pop | sel_din | sel_dout)
                             | (apb_pwrite_i & (sel_status | sel_dout))
                             | (~apb_pwrite_i & (sel_push | sel_pop)));
    assign acc_wr  = access & ~acc_err & apb_pwrite_i;
    assign acc_rd  = access & ~acc_err & ~apb_pwrite_i;

    assign push_req = acc_wr & sel_push;
    assign pop_req  = acc_wr & sel_pop;
    assign flush    = acc_wr & sel_ctrl & apb_pwdata_i[1];

    assign in_full   = (in_cnt_q == CW'(FIFO_DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == CW'(FIFO_DEPTH));
    assign out_empty = (out_cnt_q == '0);

    // Fullness/emptiness is taken before this cycle's FSM pop/push.
    assign in_push_ok = push_req & ~in_full;
    assign out_pop_ok = pop_req & ~out_empty;

    // ---------------- control / staging ----------------
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        din_d     = din_q;
        flush_d   = flush;
        if (acc_wr && sel_ctrl) ctrl_en_d = apb_pwdata_i[0];
        if (acc_wr && sel_din) begin
            for (int i = 0; i < WORDS; i++) begin
                if (woff == 6'(i)) din_d[i*DW +: DW] = apb_pwdata_i;
            end
        end
    end

    assign core_rstn_o = rstn_i & ctrl_en_q & ~flush_q;

    // ---------------- core FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        req_d       = 1'b0;
        ack_d       = 1'b0;
        core_data_d = core_data_q;
        fsm_pop     = 1'b0;
        fsm_push    = 1'b0;
        if (flush || !ctrl_en_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (!in_empty && !core_busy_i) begin
                    fsm_pop     = 1'b1;
                    core_data_d = in_mem_q[in_rptr_q];
                    req_d       = 1'b1;
                    state_d     = ST_REQ;
                end
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: if (core_valid_i && !out_full) begin
                    fsm_push = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FIFOs ----------------
    always_comb begin
        in_mem_d  = in_mem_q;
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_cnt_d  = in_cnt_q;
        out_mem_d  = out_mem_q;
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        if (flush) begin
            in_wptr_d  = '0;
            in_rptr_d  = '0;
            in_cnt_d   = '0;
            out_wptr_d = '0;
            out_rptr_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (in_push_ok) begin
                in_mem_d[in_wptr_q] = din_q;
                in_wptr_d = in_wptr_q + 1'b1;
            end
            if (fsm_pop) in_rptr_d = in_rptr_q + 1'b1;
            in_cnt_d = in_cnt_q + {{(CW-1){1'b0}}, in_push_ok} - {{(CW-1){1'b0}}, fsm_pop};

            if (fsm_push) begin
                out_mem_d[out_wptr_q] = core_data_i;
                out_wptr_d = out_wptr_q + 1'b1;
            end
            if (out_pop_ok) out_rptr_d = out_rptr_q + 1'b1;
            out_cnt_d = out_cnt_q + {{(CW-1){1'b0}}, fsm_push} - {{(CW-1){1'b0}}, out_pop_ok};
        end
    end

    // ---------------- interrupt ----------------
`ifdef CIPHER_WRAP_IRQ_EN
    logic       irq_en_q, irq_en_d;
    logic [2:0] irq_q, irq_d;
    logic [2:0] irq_set, irq_clr;

    // Hardware set wins over a simultaneous W1C clear.
    assign irq_set = {pop_req & out_empty, push_req & in_full, fsm_push};
    assign irq_clr = (acc_wr && sel_irq) ? apb_pwdata_i[2:0] : 3'b000;

    always_comb begin
        irq_en_d = (acc_wr && sel_ctrl) ? apb_pwdata_i[2] : irq_en_q;
        irq_d    = (irq_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 3'b000;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_rd    = irq_q;
    assign irq_en_rd = irq_en_q;
    assign irq_o     = irq_en_q & |irq_q;
`else
    assign irq_rd    = 3'b000;
    assign irq_en_rd = 1'b0;
    assign irq_o     = 1'b0;
`endif

    // ---------------- APB response ----------------
    always_comb begin
        prdata_d  = '0;
        pready_d  = access;
        pslverr_d = acc_err;
        if (acc_rd) begin
            if (sel_ctrl) begin
                prdata_d[0] = ctrl_en_q;
                prdata_d[2] = irq_en_rd;
            end
            if (sel_status) begin
                prdata_d[0]     = in_full;
                prdata_d[1]     = in_empty;
                prdata_d[2]     = out_full;
                prdata_d[3]     = out_empty;
                prdata_d[4]     = core_busy_i;
                prdata_d[15:8]  = 8'(in_cnt_q);
                prdata_d[23:16] = 8'(out_cnt_q);
            end
            if (sel_irq) prdata_d[2:0] = irq_rd;
            for (int i = 0; i < WORDS; i++) begin
                if (woff == 6'(i)) begin
                    if (sel_din) prdata_d = din_q[i*DW +: DW];
                    if (sel_dout && !out_empty) prdata_d = out_mem_q[out_rptr_q][i*DW +: DW];
                end
            end
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            core_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            core_data_q <= core_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_en_q  <= 1'b0;
            flush_q    <= 1'b0;
            din_q      <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                in_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
        end else begin
            ctrl_en_q  <= ctrl_en_d;
            flush_q    <= flush_d;
            din_q      <= din_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            in_mem_q   <= in_mem_d;
            out_mem_q  <= out_mem_d;
        end
    end

    assign core_req_o    = req_q;
    assign core_ack_o    = ack_q;
    assign core_data_o   = core_data_q;
    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;
    assign apb_prdata_o  = prdata_q;

endmodule
